// File: rtl/mips_exec_unit.sv
// Pipelined MIPS execute unit: single-cycle R-type ALU plus iterative mult/div
// with HI/LO, valid/ready on both sides.
module mips_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [4:0] OP_ADD  = 5'b00000, OP_ADDU = 5'b00001, OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SUBU = 5'b00011, OP_AND  = 5'b00100, OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110, OP_NOR  = 5'b00111, OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001, OP_SLL  = 5'b01010, OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100, OP_SLLV = 5'b01101, OP_SRLV = 5'b01110;
    localparam logic [4:0] OP_SRAV = 5'b01111, OP_MFHI = 5'b10100, OP_MFLO = 5'b10101;
    localparam logic [4:0] OP_MTHI = 5'b10110, OP_MTLO = 5'b10111;
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic               ovf_q, ovf_d, out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mag_q, mag_d, a_q, a_d;
    logic               neg_q, neg_d, negr_q, negr_d, divz_q, divz_d;
    logic [SHW:0]       cnt_q, cnt_d;

    logic               accept, is_mul, is_div, sa, sb, last;
    logic [WIDTH-1:0]   abs_a, abs_b, sum, diff, alu_res;
    logic               alu_ovf;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff, quo_fix, rem_fix;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    assign accept = in_valid && in_ready;
    assign is_mul = (op[4:1] == 4'b1000);
    assign is_div = (op[4:1] == 4'b1001);
    assign sa     = !op[0] && a[WIDTH-1];
    assign sb     = !op[0] && b[WIDTH-1];
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;
    assign last   = (cnt_q == CNT_LAST);

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = sum;  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
            OP_SUB:  begin alu_res = diff; alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
            OP_ADDU: alu_res = sum;
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_SLLV: alu_res = b << a[SHW-1:0];
            OP_SRLV: alu_res = b >> a[SHW-1:0];
            OP_SRAV: alu_res = $signed(b) >>> a[SHW-1:0];
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI, OP_MTLO: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // One multiply step: conditional add into the high half, then shift the
    // whole product right; the multiplier drains out of the low half.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring divide: high half is the partial remainder, low half shifts the
    // dividend out and the quotient in. rem < divisor keeps div_diff in WIDTH bits.
    assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_q});
    assign div_diff  = div_shift[WIDTH-1:0] - mag_q;
    assign div_next  = div_ge ? {div_diff, prod_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

    assign prod_fix = neg_q  ? -prod_q : prod_q;
    assign quo_fix  = neg_q  ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_fix  = negr_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && is_mul) state_d = MUL;
                      else if (accept && is_div) state_d = DIV;
            MUL, DIV: if (last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    end

    always_comb begin
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        prod_d      = prod_q;
        mag_d       = mag_q;
        a_d         = a_q;
        neg_d       = neg_q;
        negr_d      = negr_q;
        divz_d      = divz_q;
        cnt_d       = cnt_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
            if (is_mul || is_div) begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
                a_d         = a;
                neg_d       = sa ^ sb;
                negr_d      = sa;
                divz_d      = (b == '0);
                prod_d      = {{WIDTH{1'b0}}, (is_mul ? abs_b : abs_a)};
                mag_d       = is_mul ? abs_a : abs_b;
            end else begin
                result_d    = alu_res;
                ovf_d       = alu_ovf;
                out_valid_d = 1'b1;
                if (op == OP_MTHI) hi_d = a;
                if (op == OP_MTLO) lo_d = a;
            end
        end else if (state_q != IDLE) begin
            if (last) begin
                if (state_q == MUL) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (divz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                result_d    = lo_d;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
            end else begin
                prod_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            prod_q      <= '0;
            mag_q       <= '0;
            a_q         <= '0;
            neg_q       <= 1'b0;
            negr_q      <= 1'b0;
            divz_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            prod_q      <= prod_d;
            mag_q       <= mag_d;
            a_q         <= a_d;
            neg_q       <= neg_d;
            negr_q      <= negr_d;
            divz_q      <= divz_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign overflow  = ovf_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mips_exec_unit.sv
// Randomized self-checking bench for mips_exec_unit against an arithmetic
// reference model of the MIPS R-type / mult / div semantics.
module tb_mips_exec_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [4:0]  op = '0, shamt = '0;
    logic [31:0] a = '0, b = '0, result, hi, lo;
    logic        zero, overflow;

    int pass_cnt = 0, total_cnt = 0;
    logic [31:0] mhi = '0, mlo = '0;

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -SMAX - 1;

    mips_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [4:0] o, input logic [31:0] x, y, input logic [4:0] sh,
                                  input logic [31:0] mh, ml,
                                  output logic [31:0] r, output logic v, output logic [31:0] nh, nl);
        longint sx, sy, s;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0; v = 1'b0; nh = mh; nl = ml; s = 0; p = '0;
        case (o)
            5'd0:  begin s = sx + sy; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
            5'd2:  begin s = sx - sy; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
            5'd1:  r = x + y;
            5'd3:  r = x - y;
            5'd4:  r = x & y;
            5'd5:  r = x | y;
            5'd6:  r = x ^ y;
            5'd7:  r = ~(x | y);
            5'd8:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd9:  r = (x < y) ? 32'd1 : 32'd0;
            5'd10: r = y << sh;
            5'd11: r = y >> sh;
            5'd12: begin s = sy >>> sh; r = s[31:0]; end
            5'd13: r = y << x[4:0];
            5'd14: r = y >> x[4:0];
            5'd15: begin s = sy >>> x[4:0]; r = s[31:0]; end
            5'd16: begin s = sx * sy; nh = s[63:32]; nl = s[31:0]; r = nl; end
            5'd17: begin p = {32'b0, x} * {32'b0, y}; nh = p[63:32]; nl = p[31:0]; r = nl; end
            5'd18: begin
                if (y == 0) begin nl = 32'hFFFFFFFF; nh = x; end
                else begin s = sx / sy; nl = s[31:0]; s = sx % sy; nh = s[31:0]; end
                r = nl;
            end
            5'd19: begin
                if (y == 0) begin nl = 32'hFFFFFFFF; nh = x; end
                else begin nl = x / y; nh = x % y; end
                r = nl;
            end
            5'd20: r = mh;
            5'd21: r = ml;
            5'd22: begin nh = x; r = x; end
            5'd23: begin nl = x; r = x; end
            default: ;
        endcase
    endfunction

    // Issue one op, wait for its result; lat = edges after the accept edge
    // until out_valid is visible, busy = cycles in_ready was high meanwhile.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, y, input logic [4:0] sh,
                          output logic [31:0] r, output logic v, z, output logic [31:0] h, l,
                          output int lat, output int busy);
        int n;
        @(negedge clk);
        op = o; a = x; b = y; shamt = sh; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lat = 0; busy = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        if (n >= 200) lat = -1;
        r = result; v = overflow; z = zero; h = hi; l = lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({result, hi, lo, out_valid, overflow, zero} !== {96'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state got res=%h hi=%h lo=%h v=%b ov=%b z=%b", result, hi, lo, out_valid, overflow, zero);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_ready got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_addsub();
        logic [31:0] r, h, l; logic v, z; int lat, bb;
        run_op(5'd0, 32'h7FFFFFFF, 32'h1, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'h80000000 || v !== 1'b1 || z !== 1'b0 || lat != 0)
            $display("FAIL add_ovf got r=%h ov=%b z=%b lat=%0d exp 80000000/1/0/0", r, v, z, lat);
        else pass_cnt++;
        run_op(5'd1, 32'h7FFFFFFF, 32'h1, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'h80000000 || v !== 1'b0 || lat != 0)
            $display("FAIL addu got r=%h ov=%b lat=%0d exp 80000000/0/0", r, v, lat);
        else pass_cnt++;
        run_op(5'd2, 32'h80000000, 32'h1, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'h7FFFFFFF || v !== 1'b1)
            $display("FAIL sub_ovf got r=%h ov=%b exp 7fffffff/1", r, v);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        logic [31:0] r, h, l; logic v, z; int lat, bb;
        run_op(5'd12, 32'h0, 32'hF0000000, 5'd4, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'hFF000000) $display("FAIL sra got %h exp ff000000", r); else pass_cnt++;
        run_op(5'd11, 32'h0, 32'hF0000000, 5'd4, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'h0F000000) $display("FAIL srl got %h exp 0f000000", r); else pass_cnt++;
        run_op(5'd15, 32'h24, 32'hF0000000, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'hFF000000) $display("FAIL srav got %h exp ff000000", r); else pass_cnt++;
        run_op(5'd10, 32'h0, 32'h12345678, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'h12345678) $display("FAIL sll_zero got %h exp 12345678", r); else pass_cnt++;
    endtask

    task automatic test_random_alu();
        logic [31:0] r, h, l, x, y, er, eh, el; logic v, z, ev; logic [4:0] o, sh; int lat, bb;
        for (int i = 0; i < 60; i++) begin
            o = 5'($urandom_range(0, 31));
            if (o inside {[16:19]}) o = 5'd2;
            x = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            sh = 5'($urandom);
            model(o, x, y, sh, mhi, mlo, er, ev, eh, el);
            run_op(o, x, y, sh, r, v, z, h, l, lat, bb);
            total_cnt++;
            if (r !== er || v !== ev || z !== (er == 0) || h !== eh || l !== el || lat != 0)
                $display("FAIL rand_alu op=%0d a=%h b=%h got r=%h ov=%b hi=%h lo=%h lat=%0d exp r=%h ov=%b hi=%h lo=%h lat=0",
                         o, x, y, r, v, h, l, lat, er, ev, eh, el);
            else pass_cnt++;
            mhi = eh; mlo = el;
        end
    endtask

    task automatic test_muldiv();
        logic [31:0] r, h, l, x, y, er, eh, el; logic v, z, ev; logic [4:0] o; int lat, bb;
        run_op(5'd16, 32'hFFFFFFFD, 32'd7, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB || r !== 32'hFFFFFFEB)
            $display("FAIL mult_val got hi=%h lo=%h r=%h exp ffffffff/ffffffeb", h, l, r);
        else pass_cnt++;
        total_cnt++;
        if (lat != 33 || bb != 0)
            $display("FAIL mult_lat got lat=%0d busy=%0d exp 33/0", lat, bb);
        else pass_cnt++;
        run_op(5'd20, 32'h0, 32'h0, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (r !== 32'hFFFFFFFF) $display("FAIL mfhi got %h exp ffffffff", r); else pass_cnt++;
        run_op(5'd18, 32'hFFFFFFF9, 32'd2, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF)
            $display("FAIL div_neg got lo=%h hi=%h exp fffffffd/ffffffff", l, h);
        else pass_cnt++;
        run_op(5'd19, 32'd5, 32'd0, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (l !== 32'hFFFFFFFF || h !== 32'd5 || lat != 33)
            $display("FAIL divu_zero got lo=%h hi=%h lat=%0d exp ffffffff/5/33", l, h, lat);
        else pass_cnt++;
        run_op(5'd18, 32'h80000000, 32'hFFFFFFFF, 5'd0, r, v, z, h, l, lat, bb);
        total_cnt++;
        if (l !== 32'h80000000 || h !== 32'h0)
            $display("FAIL div_min got lo=%h hi=%h exp 80000000/0", l, h);
        else pass_cnt++;
        mhi = h; mlo = l;
        for (int i = 0; i < 16; i++) begin
            o = 5'($urandom_range(16, 19));
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            model(o, x, y, 5'd0, mhi, mlo, er, ev, eh, el);
            run_op(o, x, y, 5'd0, r, v, z, h, l, lat, bb);
            total_cnt++;
            if (r !== er || v !== 1'b0 || h !== eh || l !== el || lat != 33 || bb != 0)
                $display("FAIL rand_muldiv op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d exp hi=%h lo=%h lat=33",
                         o, x, y, h, l, lat, eh, el);
            else pass_cnt++;
            mhi = eh; mlo = el;
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        op = 5'd2; a = 32'd5; b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 op = 5'd0; a = 32'd1; b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0 ||
                in_ready !== 1'b0 || hi !== mhi || lo !== mlo)
                $display("FAIL bp_hold cyc=%0d got v=%b r=%h z=%b rdy=%b exp 1/0/1/0", i, out_valid, result, zero, in_ready);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got in_ready=%b exp 1", in_ready); else pass_cnt++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'd3)
            $display("FAIL bp_next got v=%b r=%h exp 1/3", out_valid, result);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] x, y, er, eh, el, e; logic ev; logic [4:0] o, sh;
        @(negedge clk);
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front();
                total_cnt++;
                if (out_valid !== 1'b1 || result !== e)
                    $display("FAIL b2b idx=%0d got v=%b r=%h exp 1/%h", i - 1, out_valid, result, e);
                else pass_cnt++;
            end
            if (i < 20) begin
                total_cnt++;
                if (in_ready !== 1'b1) $display("FAIL b2b_ready idx=%0d got %b exp 1", i, in_ready);
                else pass_cnt++;
                o = 5'($urandom_range(0, 15));
                if ($urandom_range(0, 4) == 0) o = 5'($urandom_range(20, 23));
                x = $urandom; y = $urandom; sh = 5'($urandom);
                model(o, x, y, sh, mhi, mlo, er, ev, eh, el);
                mhi = eh; mlo = el;
                exp_q.push_back(er);
                op = o; a = x; b = y; shamt = sh; in_valid = 1'b1;
                @(negedge clk);
            end else in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        op = 5'd17; a = $urandom | 32'h1; b = $urandom | 32'h1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rst_mid_busy got rdy=%b v=%b exp 0/0", in_ready, out_valid);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({result, hi, lo, out_valid, overflow, zero} !== {96'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL rst_mid_clear got res=%h hi=%h lo=%h v=%b z=%b", result, hi, lo, out_valid, zero);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mhi = '0; mlo = '0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", in_ready); else pass_cnt++;
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        total_cnt++;
        if (seen != 0) $display("FAIL rst_mid_stale got %0d valid cycles exp 0", seen); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_shift();
        test_random_alu();
        test_muldiv();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
